// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Access-size and error-cause encodings for sized_data_memory.
// Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10,
    ERR_SIZE     = 2'b11
  } err_cause_e;

  // Reserved size reports 4 so range arithmetic stays well defined.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_load_align.sv
`default_nettype none
// ============================================================================
// Module   : dmem_load_align
// Purpose  : Right-justifies and extends big-endian load bytes by access size.
// Revision : 1.0  initial release
// ============================================================================
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] raw_bytes,
  input  logic [1:0]  size,
  input  logic        unsigned_load,
  output logic [31:0] result
);

  logic sign_bit;

  always_comb begin
    sign_bit = 1'b0;
    result   = raw_bytes;
    case (size)
      SZ_BYTE: begin
        sign_bit = ~unsigned_load & raw_bytes[31];
        result   = {{24{sign_bit}}, raw_bytes[31:24]};
      end
      SZ_HALF: begin
        sign_bit = ~unsigned_load & raw_bytes[31];
        result   = {{16{sign_bit}}, raw_bytes[31:16]};
      end
      default: result = raw_bytes;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sized_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : sized_data_memory
// Purpose  : Big-endian byte-addressed data memory with sized, checked access.
//            DMEM_WRITE_FIRST_EN: same-cycle load sees the store's bytes.
// Revision : 1.0  initial release
// ============================================================================
module sized_data_memory
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [1:0]        size,
  input  logic              unsignedLoad,
  input  logic [31:0]       writeData,
  output logic [31:0]       readData,
  output logic              readValid,
  output logic              accessErr,
  output logic [1:0]        errCause
);

  localparam int              IDX_W     = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH_BYTES);

  logic [7:0]       mem_q [DEPTH_BYTES];

  logic [2:0]       n_bytes;
  logic [ADDR_W:0]  last_addr;
  err_cause_e       cause;
  logic [IDX_W-1:0] lane_idx [4];
  logic [5:0]       wr_shamt;
  logic [31:0]      wr_aligned;
  logic [3:0]       wr_en;
  logic [31:0]      raw_bytes;
  logic [31:0]      load_result;

  logic [31:0] read_data_d,  read_data_q;
  logic        read_valid_d, read_valid_q;
  logic        access_err_d, access_err_q;
  logic [1:0]  err_cause_d,  err_cause_q;

  // Extra top bit keeps address+bytes-1 from wrapping at ADDR_W.
  always_comb begin
    n_bytes   = size_bytes(size);
    last_addr = {1'b0, address} + (ADDR_W+1)'(n_bytes) - (ADDR_W+1)'(1);
    cause     = ERR_NONE;
    if (size == SZ_RSVD)
      cause = ERR_SIZE;
    else if ((size == SZ_HALF && address[0]) ||
             (size == SZ_WORD && address[1:0] != 2'b00))
      cause = ERR_MISALIGN;
    else if (last_addr >= DEPTH_EXT)
      cause = ERR_RANGE;
  end

  // Lane i is byte address+i; the store data is left-justified so lane 0
  // always carries the most significant stored byte.
  always_comb begin
    wr_shamt   = {3'd4 - n_bytes, 3'b000};
    wr_aligned = writeData << wr_shamt;
    raw_bytes  = '0;
    for (int i = 0; i < 4; i++) begin
      lane_idx[i] = address[IDX_W-1:0] + IDX_W'(i);
      wr_en[i]    = rst_n && memWrite && (cause == ERR_NONE) && (3'(i) < n_bytes);
`ifdef DMEM_WRITE_FIRST_EN
      raw_bytes[31-8*i -: 8] = wr_en[i] ? wr_aligned[31-8*i -: 8] : mem_q[lane_idx[i]];
`else
      raw_bytes[31-8*i -: 8] = mem_q[lane_idx[i]];
`endif
    end
  end

  dmem_load_align u_load_align (
    .raw_bytes     (raw_bytes),
    .size          (size),
    .unsigned_load (unsignedLoad),
    .result        (load_result)
  );

  always_comb begin
    read_valid_d = memRead && (cause == ERR_NONE);
    read_data_d  = read_valid_d ? load_result : read_data_q;
    access_err_d = (memRead || memWrite) && (cause != ERR_NONE);
    err_cause_d  = access_err_d ? cause : ERR_NONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      access_err_q <= 1'b0;
      err_cause_q  <= ERR_NONE;
    end else begin
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      access_err_q <= access_err_d;
      err_cause_q  <= err_cause_d;
    end
  end

  // Storage is deliberately not reset; wr_en already excludes reset cycles.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en[i])
        mem_q[lane_idx[i]] <= wr_aligned[31-8*i -: 8];
    end
  end

  assign readData  = read_data_q;
  assign readValid = read_valid_q;
  assign accessErr = access_err_q;
  assign errCause  = err_cause_q;

endmodule
`default_nettype wire

// File: doc/sized_data_memory.md
SIZED_DATA_MEMORY -- requirements
Module: sized_data_memory

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 1024; memory size in bytes, power of two, minimum 8.
REQ-002 SHALL have parameter ADDR_W, default 32; byte-address width.
REQ-003 SHALL have port clk, input, 1 bit; single clock, all state updates on posedge.
REQ-004 SHALL have port rst_n, input, 1 bit; reset, synchronous, active-low.
REQ-005 SHALL have port memRead, input, 1 bit; load request this cycle.
REQ-006 SHALL have port memWrite, input, 1 bit; store request this cycle.
REQ-007 SHALL have port address, input, ADDR_W bits; byte address of the access.
REQ-008 SHALL have port size, input, 2 bits; 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 SHALL have port unsignedLoad, input, 1 bit; 1 zero-extends, 0 sign-extends byte and halfword loads.
REQ-010 SHALL have port writeData, input, 32 bits; store data, right-justified.
REQ-011 SHALL have port readData, output, 32 bits; registered load result.
REQ-012 SHALL have port readValid, output, 1 bit; one-cycle pulse, readData is valid.
REQ-013 SHALL have port accessErr, output, 1 bit; one-cycle pulse, the previous request was rejected.
REQ-014 SHALL have port errCause, output, 2 bits; 00 none, 01 misaligned, 10 out of range, 11 bad size.

Function
REQ-015 Storage SHALL be a byte array of DEPTH_BYTES entries in big-endian order: the lowest address holds the most significant byte.
REQ-016 A byte store SHALL write writeData[7:0] to address; a halfword store SHALL write [15:8],[7:0] to address and address+1; a word store SHALL write [31:24]..[7:0] to address..address+3.
REQ-017 A load SHALL drive readData and readValid on the clock edge after the request; latency is exactly 1 cycle, with no back-pressure.
REQ-018 A byte or halfword load SHALL be placed in the LSBs and extended per unsignedLoad; a word load SHALL ignore unsignedLoad.
REQ-019 readData SHALL hold its last value when no valid load completes.
REQ-020 A request with size=11 SHALL be rejected with cause 11.
REQ-021 A halfword with address[0]=1, or a word with address[1:0]!=0, SHALL be rejected with cause 01.
REQ-022 An access with address+bytes-1 >= DEPTH_BYTES SHALL be rejected with cause 10, and the sum SHALL be computed without ADDR_W wrap.
REQ-023 Error priority SHALL be 11 > 01 > 10.
REQ-024 A rejected request SHALL NOT modify memory, SHALL NOT pulse readValid and SHALL leave readData unchanged; accessErr and errCause SHALL be registered, 1-cycle latency.
REQ-025 When memRead and memWrite are both high, both SHALL be performed using the same address, size and error check; the read data source is set by REQ-031.
REQ-026 When neither memRead nor memWrite is high, accessErr SHALL be 0 and errCause 00 on the next cycle.

Reset
REQ-027 While rst_n=0 at posedge: readData=0, readValid=0, accessErr=0, errCause=00.
REQ-028 Memory contents SHALL NOT be reset; a store coinciding with rst_n=0 SHALL be discarded.
REQ-029 A load issued in the cycle before reset asserts SHALL NOT produce a readValid pulse.

Configuration
REQ-030 Macro DMEM_WRITE_FIRST_EN SHALL select the behaviour of simultaneous reads and writes to overlapping bytes.
REQ-031 With DMEM_WRITE_FIRST_EN defined, overlapping bytes SHALL return the new writeData bytes; without it, they SHALL return the pre-write contents (read-before-write).

Structure
REQ-032 Package dmem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD) and the errCause encodings.
REQ-033 Load extraction and extension SHALL be a combinational sub-module dmem_load_align (inputs: 4 raw bytes, size, unsignedLoad; output: 32-bit result).

Verification
REQ-034 Word store 0x07FFDFF0 @0x4, then word load @0x4 -> readData=0x07FFDFF0, readValid pulse 1 cycle after the load.
REQ-035 Byte load @0x4 with unsignedLoad=0 -> 0x00000007; byte load @0x7 with unsignedLoad=0 -> 0xFFFFFFF0; half load @0x6 with unsignedLoad=1 -> 0x0000DFF0.
REQ-036 Half store 0x1234 @0x3 -> accessErr=1, errCause=01, memory unchanged; word load @0x1020 (DEPTH 1024) -> errCause=10, no readValid; size=11 @0x1 -> errCause=11.
REQ-037 Load and store both high on the same cycle to word @0x8 (old 0xAAAAAAAA, new 0x55555555) -> readData=0xAAAAAAAA without the macro, 0x55555555 with it; a later load returns 0x55555555.
REQ-038 Word load issued, rst_n=0 on the next edge -> readValid=0, readData=0; memory still holds 0x07FFDFF0 @0x4 after reset.
